// File: rtl/fx1_result_pipe_pkg.sv
// rtl/fx1_result_pipe_pkg.sv - FX1 result pipe constants, stage record layout and helpers (optional parity: FX1_PARITY_EN)
package fx1_result_pipe_pkg;

    localparam int FX1_LATENCY     = 2;
    localparam int FX1_MAX_LATENCY = 7;
    localparam int REG_ADDR_W      = 7;
    localparam int FX1_DATA_W      = 128;
    localparam int FX1_PAR_W       = FX1_DATA_W / 32;

    // Layout of one pipeline stage entry at the default widths.
    typedef struct packed {
        logic                   valid;
        logic [REG_ADDR_W-1:0]  rt_addr;
        logic [0:FX1_DATA_W-1]  data;
`ifdef FX1_PARITY_EN
        logic [FX1_PAR_W-1:0]   parity;
`endif
    } fx1_stage_t;

    // Number of live stages; the vector is wide enough for the deepest legal pipe.
    function automatic int unsigned fx1_count_ones(input logic [FX1_MAX_LATENCY-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < FX1_MAX_LATENCY; i++) begin
            n = n + {31'd0, bits[i]};
        end
        return n;
    endfunction

    // Even parity over one 32-bit word of the result.
    function automatic logic fx1_even_parity32(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fx1_result_pipe_stage.sv
// rtl/fx1_result_pipe_stage.sv - one FX1 result stage register with hold/kill/load (parity field under FX1_PARITY_EN)
module fx1_pipe_stage #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold_i,
    input  logic                  kill_i,
    input  logic                  load_valid_i,
    input  logic [ADDR_W-1:0]     load_addr_i,
    input  logic [0:DATA_W-1]     load_data_i,
`ifdef FX1_PARITY_EN
    input  logic [DATA_W/32-1:0]  load_par_i,
    output logic [DATA_W/32-1:0]  par_o,
`endif
    output logic                  valid_o,
    output logic                  valid_nxt_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [0:DATA_W-1]     data_o
);

    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [0:DATA_W-1]    data_q, data_d;
`ifdef FX1_PARITY_EN
    logic [DATA_W/32-1:0] par_q, par_d;
`endif

    // Holding keeps the entry but still honours a kill; otherwise take the upstream offer.
    always_comb begin
        valid_d = load_valid_i;
        addr_d  = load_addr_i;
        data_d  = load_data_i;
`ifdef FX1_PARITY_EN
        par_d   = load_par_i;
`endif
        if (hold_i) begin
            valid_d = valid_q & ~kill_i;
            addr_d  = addr_q;
            data_d  = data_q;
`ifdef FX1_PARITY_EN
            par_d   = par_q;
`endif
        end
    end

    // Stage register; reset clears payload as well as the live bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef FX1_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef FX1_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
`ifdef FX1_PARITY_EN
    assign par_o       = par_q;
`endif

endmodule

// File: rtl/fx1_result_pipe.sv
// rtl/fx1_result_pipe.sv - FX1 result pipe: latency stages, forwarding taps, single writeback (optional parity: FX1_PARITY_EN)
module fx1_result_pipe
    import fx1_result_pipe_pkg::*;
#(
    parameter int LATENCY = FX1_LATENCY,
    parameter int DATA_W  = FX1_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [ADDR_W-1:0]              in_rt_addr,
    input  logic [0:DATA_W-1]              in_result,
    input  logic                           stall,
    input  logic                           flush_in,
    input  logic [0:LATENCY-1]             flush_mask,
    output logic [0:LATENCY-1]             fwd_valid,
    output logic [0:LATENCY*ADDR_W-1]      fwd_rt_addr,
    output logic [0:LATENCY*DATA_W-1]      fwd_data,
    output logic                           wb_valid,
    output logic [ADDR_W-1:0]              wb_rt_addr,
    output logic [0:DATA_W-1]              wb_data,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight
`ifdef FX1_PARITY_EN
    ,
    output logic                           parity_err
`endif
);

    localparam int IF_W = $clog2(LATENCY + 1);

    logic [0:LATENCY-1]          v_q;
    logic [0:LATENCY-1]          v_d;
    logic [0:LATENCY-1]          live;
    logic [ADDR_W-1:0]           addr_q [LATENCY];
    logic [0:DATA_W-1]           data_q [LATENCY];
    logic [FX1_MAX_LATENCY-1:0]  v_d_ext;
    logic [IF_W-1:0]             in_flight_q, in_flight_d;

    // A flushed stage stops being visible to bypass and writeback in the same cycle.
    assign live = v_q & ~flush_mask;

`ifdef FX1_PARITY_EN
    localparam int PAR_W = DATA_W / 32;
    logic [PAR_W-1:0] par_in;
    logic [PAR_W-1:0] par_wb;
    logic [PAR_W-1:0] par_q [LATENCY];
    logic             err_q, err_d;

    // Parity generated on the incoming result and re-derived on the write data.
    always_comb begin
        par_in = '0;
        par_wb = '0;
        for (int k = 0; k < PAR_W; k++) begin
            par_in[k] = fx1_even_parity32(in_result[k*32 +: 32]);
            par_wb[k] = fx1_even_parity32(wb_data[k*32 +: 32]);
        end
    end
`endif

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic               ld_valid;
        logic [ADDR_W-1:0]  ld_addr;
        logic [0:DATA_W-1]  ld_data;
`ifdef FX1_PARITY_EN
        logic [PAR_W-1:0]   ld_par;
`endif

        if (i == 0) begin : g_head
            assign ld_valid = in_valid & ~flush_in;
            assign ld_addr  = in_rt_addr;
            assign ld_data  = in_result;
`ifdef FX1_PARITY_EN
            assign ld_par   = par_in;
`endif
        end else begin : g_body
            assign ld_valid = live[i-1];
            assign ld_addr  = addr_q[i-1];
            assign ld_data  = data_q[i-1];
`ifdef FX1_PARITY_EN
            assign ld_par   = par_q[i-1];
`endif
        end

        fx1_pipe_stage #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk          (clk),
            .reset        (reset),
            .hold_i       (stall),
            .kill_i       (flush_mask[i]),
            .load_valid_i (ld_valid),
            .load_addr_i  (ld_addr),
            .load_data_i  (ld_data),
`ifdef FX1_PARITY_EN
            .load_par_i   (ld_par),
            .par_o        (par_q[i]),
`endif
            .valid_o      (v_q[i]),
            .valid_nxt_o  (v_d[i]),
            .addr_o       (addr_q[i]),
            .data_o       (data_q[i])
        );

        assign fwd_rt_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
        assign fwd_data[i*DATA_W +: DATA_W]    = data_q[i];
    end

    // Live count that the stages will hold after this edge.
    always_comb begin
        v_d_ext = '0;
        for (int i = 0; i < LATENCY; i++) begin
            v_d_ext[i] = v_d[i];
        end
        in_flight_d = IF_W'(fx1_count_ones(v_d_ext));
    end

    // In-flight counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    assign fwd_valid  = live;
    assign in_flight  = in_flight_q;
    // Stall suppresses the write so a held last stage writes exactly once.
    assign wb_valid   = live[LATENCY-1] & ~stall;
    assign wb_rt_addr = addr_q[LATENCY-1];
    assign wb_data    = data_q[LATENCY-1];

`ifdef FX1_PARITY_EN
    assign err_d      = err_q | (wb_valid & (par_wb != par_q[LATENCY-1]));
    assign parity_err = err_d;

    // Sticky parity error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_fx1_result_pipe.sv
// tb/tb_fx1_result_pipe.sv - directed self-checking bench for fx1_result_pipe (parity case under FX1_PARITY_EN)
module tb_fx1_result_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [6:0]   in_rt_addr;
    logic [0:127] in_result;
    logic         stall;
    logic         flush_in;
    logic [0:1]   flush_mask;
    logic [0:1]   fwd_valid;
    logic [0:13]  fwd_rt_addr;
    logic [0:255] fwd_data;
    logic         wb_valid;
    logic [6:0]   wb_rt_addr;
    logic [0:127] wb_data;
    logic [1:0]   in_flight;
`ifdef FX1_PARITY_EN
    logic         parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA = 128'h11111111222222223333333344444444;
    localparam logic [127:0] DB = 128'hDEADBEEF00000000CAFEF00D12345678;
    localparam logic [127:0] DC = 128'hFFFFFFFF00000001800000007FFFFFFF;
    localparam logic [127:0] DD = 128'h0F0F0F0FF0F0F0F0A5A5A5A55A5A5A5A;

    always #5 clk = ~clk;

    fx1_result_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_rt_addr  (in_rt_addr),
        .in_result   (in_result),
        .stall       (stall),
        .flush_in    (flush_in),
        .flush_mask  (flush_mask),
        .fwd_valid   (fwd_valid),
        .fwd_rt_addr (fwd_rt_addr),
        .fwd_data    (fwd_data),
        .wb_valid    (wb_valid),
        .wb_rt_addr  (wb_rt_addr),
        .wb_data     (wb_data),
        .in_flight   (in_flight)
`ifdef FX1_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] rt, input logic [127:0] d);
        in_valid   = v;
        in_rt_addr = rt;
        in_result  = d;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush_in = 1'b0; flush_mask = 2'b00;
        drive(1'b0, 7'd0, '0);
        tick(); tick();
        chk("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
        chk("rst_in_flight", {126'd0, in_flight}, 128'd0);
        chk("rst_fwd_valid", {126'd0, fwd_valid}, 128'd0);
        chk("rst_fwd_rt", {114'd0, fwd_rt_addr}, 128'd0);
        chk("rst_fwd_data_s1", fwd_data[128:255], 128'd0);
        chk("rst_wb_data", wb_data, 128'd0);
        reset = 1'b0;

        // Single instruction, no stall
        drive(1'b1, 7'd5, D1);
        tick(); drive(1'b0, 7'd0, '0);
        chk("t1_fwd_valid_s0", {126'd0, fwd_valid}, 128'h2);
        chk("t1_fwd_rt_s0", {121'd0, fwd_rt_addr[0:6]}, 128'd5);
        chk("t1_fwd_data_s0", fwd_data[0:127], D1);
        chk("t1_in_flight_a", {126'd0, in_flight}, 128'd1);
        chk("t1_wb_early", {127'd0, wb_valid}, 128'd0);
        tick();
        chk("t1_wb_valid", {127'd0, wb_valid}, 128'd1);
        chk("t1_wb_rt", {121'd0, wb_rt_addr}, 128'd5);
        chk("t1_wb_data", wb_data, D1);
        chk("t1_in_flight_b", {126'd0, in_flight}, 128'd1);
        chk("t1_fwd_rt_s1", {121'd0, fwd_rt_addr[7:13]}, 128'd5);
        tick();
        chk("t1_wb_once", {127'd0, wb_valid}, 128'd0);
        chk("t1_in_flight_c", {126'd0, in_flight}, 128'd0);

        // Back-to-back 1,2,3
        drive(1'b1, 7'd1, DA);
        tick(); drive(1'b1, 7'd2, DB);
        chk("t2_wb_idle", {127'd0, wb_valid}, 128'd0);
        chk("t2_in_flight_1", {126'd0, in_flight}, 128'd1);
        tick(); drive(1'b1, 7'd3, DC);
        chk("t2_wb1_valid", {127'd0, wb_valid}, 128'd1);
        chk("t2_wb1_rt", {121'd0, wb_rt_addr}, 128'd1);
        chk("t2_wb1_data", wb_data, DA);
        chk("t2_in_flight_peak", {126'd0, in_flight}, 128'd2);
        chk("t2_fwd_valid_both", {126'd0, fwd_valid}, 128'h3);
        tick(); drive(1'b0, 7'd0, '0);
        chk("t2_wb2_valid", {127'd0, wb_valid}, 128'd1);
        chk("t2_wb2_rt", {121'd0, wb_rt_addr}, 128'd2);
        chk("t2_wb2_data", wb_data, DB);
        tick();
        chk("t2_wb3_valid", {127'd0, wb_valid}, 128'd1);
        chk("t2_wb3_rt", {121'd0, wb_rt_addr}, 128'd3);
        chk("t2_in_flight_tail", {126'd0, in_flight}, 128'd1);
        tick();
        chk("t2_wb_done", {127'd0, wb_valid}, 128'd0);
        chk("t2_in_flight_done", {126'd0, in_flight}, 128'd0);

        // Stall while rt=7 sits in the last stage
        drive(1'b1, 7'd7, DC);
        tick(); drive(1'b0, 7'd0, '0);
        tick();
        chk("t3_wb_before_stall", {127'd0, wb_valid}, 128'd1);
        stall = 1'b1; #1;
        chk("t3_wb_stall_comb", {127'd0, wb_valid}, 128'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_wb_stalled", {127'd0, wb_valid}, 128'd0);
            chk("t3_hold_fwd_valid", {126'd0, fwd_valid}, 128'h1);
            chk("t3_hold_in_flight", {126'd0, in_flight}, 128'd1);
        end
        stall = 1'b0; #1;
        chk("t3_wb_release", {127'd0, wb_valid}, 128'd1);
        chk("t3_wb_rt", {121'd0, wb_rt_addr}, 128'd7);
        chk("t3_wb_data", wb_data, DC);
        tick();
        chk("t3_wb_once", {127'd0, wb_valid}, 128'd0);
        chk("t3_in_flight_done", {126'd0, in_flight}, 128'd0);

        // Flush stage 0 while not stalled
        drive(1'b1, 7'd9, DD);
        tick(); drive(1'b0, 7'd0, '0);
        flush_mask = 2'b10; #1;
        chk("t4_fwd_valid_masked", {126'd0, fwd_valid}, 128'd0);
        chk("t4_in_flight_pre", {126'd0, in_flight}, 128'd1);
        tick(); flush_mask = 2'b00;
        chk("t4_no_wb_a", {127'd0, wb_valid}, 128'd0);
        chk("t4_fwd_valid_after", {126'd0, fwd_valid}, 128'd0);
        chk("t4_in_flight_after", {126'd0, in_flight}, 128'd0);
        tick();
        chk("t4_no_wb_b", {127'd0, wb_valid}, 128'd0);

        // Flush beats stall: kill last stage in place, stage 0 holds
        drive(1'b1, 7'h21, DA);
        tick(); drive(1'b1, 7'h22, DB);
        tick(); drive(1'b0, 7'd0, '0);
        stall = 1'b1; flush_mask = 2'b01; #1;
        chk("t5_wb_killed", {127'd0, wb_valid}, 128'd0);
        chk("t5_fwd_valid_mask", {126'd0, fwd_valid}, 128'h2);
        tick(); flush_mask = 2'b00;
        chk("t5_fwd_valid_hold", {126'd0, fwd_valid}, 128'h2);
        chk("t5_in_flight", {126'd0, in_flight}, 128'd1);
        chk("t5_fwd_rt_s0", {121'd0, fwd_rt_addr[0:6]}, 128'h22);
        stall = 1'b0;
        tick();
        chk("t5_wb_valid", {127'd0, wb_valid}, 128'd1);
        chk("t5_wb_rt", {121'd0, wb_rt_addr}, 128'h22);
        chk("t5_wb_data", wb_data, DB);
        tick();
        chk("t5_in_flight_done", {126'd0, in_flight}, 128'd0);

        // Flush beats acceptance
        drive(1'b1, 7'h30, DC); flush_in = 1'b1;
        tick(); drive(1'b0, 7'd0, '0); flush_in = 1'b0;
        chk("t6_in_flight", {126'd0, in_flight}, 128'd0);
        chk("t6_fwd_valid", {126'd0, fwd_valid}, 128'd0);
        tick();
        chk("t6_no_wb", {127'd0, wb_valid}, 128'd0);

        // Asynchronous reset with two in flight
        drive(1'b1, 7'h41, DA);
        tick(); drive(1'b1, 7'h42, DB);
        tick(); drive(1'b0, 7'd0, '0);
        chk("t7_pre_in_flight", {126'd0, in_flight}, 128'd2);
        chk("t7_pre_wb_valid", {127'd0, wb_valid}, 128'd1);
        #2 reset = 1'b1; #1;
        chk("t7_rst_wb_valid", {127'd0, wb_valid}, 128'd0);
        chk("t7_rst_in_flight", {126'd0, in_flight}, 128'd0);
        chk("t7_rst_fwd_valid", {126'd0, fwd_valid}, 128'd0);
        chk("t7_rst_fwd_data_s0", fwd_data[0:127], 128'd0);
        chk("t7_rst_wb_data", wb_data, 128'd0);
        tick(); reset = 1'b0;
        tick();
        chk("t7_post_wb_a", {127'd0, wb_valid}, 128'd0);
        tick();
        chk("t7_post_wb_b", {127'd0, wb_valid}, 128'd0);
        chk("t7_post_in_flight", {126'd0, in_flight}, 128'd0);

`ifdef FX1_PARITY_EN
        // Corrupt last-stage data during its writeback cycle
        drive(1'b1, 7'h50, D1);
        tick(); drive(1'b0, 7'd0, '0);
        tick();
        chk("t8_par_clean", {127'd0, parity_err}, 128'd0);
        force dut.g_stage[1].u_stage.data_q = D1 ^ 128'h1;
        #1;
        chk("t8_par_err_wb", {127'd0, parity_err}, 128'd1);
        release dut.g_stage[1].u_stage.data_q;
        tick();
        chk("t8_par_sticky", {127'd0, parity_err}, 128'd1);
        tick();
        chk("t8_par_sticky_b", {127'd0, parity_err}, 128'd1);
        reset = 1'b1; #1;
        chk("t8_par_reset", {127'd0, parity_err}, 128'd0);
        tick(); reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
